// File: rtl/wb_stage.sv
// wb_stage: writeback stage. Merges the single-cycle ALU result stream and a small
// load-completion FIFO onto the register file's single write port. The FIFO head
// loses to a live ALU result; a starvation counter eventually asks decode to stall.
//
// Optional feature macro: WB_LOAD_FMT_EN
//   defined   - load data is sign/zero-extended by funct3 and byte offset at enqueue,
//               and an illegal funct3 writes 0 and pulses o_ld_err.
//   undefined - load data is stored and written unchanged, o_ld_err is tied to 0.

module wb_stage #(
    parameter int unsigned LD_FIFO_DEPTH = 2,  // power of two, >= 2
    parameter int unsigned STARVE_LIMIT  = 4   // >= 1
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_alu_valid,
    input  logic [4:0]  i_alu_rd_addr,
    input  logic [31:0] i_alu_rd_data,

    input  logic        i_ld_valid,
    output logic        o_ld_ready,
    input  logic [4:0]  i_ld_rd_addr,
    input  logic [31:0] i_ld_data,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_byte_off,

    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd_data,
    output logic        o_write_en,
    output logic        o_ld_pending,
    output logic        o_stall_req,
    output logic        o_ld_err
);

    localparam int unsigned PTR_W = (LD_FIFO_DEPTH > 1) ? $clog2(LD_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(LD_FIFO_DEPTH + 1);
    localparam int unsigned STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(LD_FIFO_DEPTH);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    // Load-completion FIFO storage (data path only, no reset needed)
    logic [4:0]  q_addr [LD_FIFO_DEPTH];
    logic [31:0] q_data [LD_FIFO_DEPTH];
    logic        q_err  [LD_FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    logic [STV_W-1:0] starve_q, starve_d;
    logic             stall_q, stall_d;

    logic [4:0]  rd_addr_q;
    logic [31:0] rd_data_q;
    logic        write_en_q;
    logic        ld_pending_q;
    logic        ld_err_q;

    logic        fifo_nonempty;
    logic        enq;
    logic        deq;
    logic        alu_win;

    logic [31:0] enq_data;
    logic        enq_err;

    logic [4:0]  head_addr;
    logic [31:0] head_data;
    logic        head_err;

    assign fifo_nonempty = (count_q != '0);

    // Ready reflects the count at the start of the cycle; a same-cycle dequeue
    // never opens a slot for an enqueue.
    assign o_ld_ready = !i_rst && (count_q != FIFO_FULL);
    assign enq        = i_ld_valid && o_ld_ready;

    // An ALU result for x0 does not claim the port, so the load head may drain.
    assign alu_win = i_alu_valid && (i_alu_rd_addr != 5'd0);
    assign deq     = !alu_win && fifo_nonempty;

    assign head_addr = q_addr[rd_ptr_q];
    assign head_data = q_data[rd_ptr_q];
    assign head_err  = q_err[rd_ptr_q];

`ifdef WB_LOAD_FMT_EN
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Select the addressed byte/half of the aligned word, then extend by funct3
    always_comb begin
        ld_byte  = 8'h00;
        enq_data = 32'h0;
        enq_err  = 1'b0;
        case (i_ld_byte_off)
            2'd0:    ld_byte = i_ld_data[7:0];
            2'd1:    ld_byte = i_ld_data[15:8];
            2'd2:    ld_byte = i_ld_data[23:16];
            default: ld_byte = i_ld_data[31:24];
        endcase
        ld_half = i_ld_byte_off[1] ? i_ld_data[31:16] : i_ld_data[15:0];
        case (i_ld_funct3)
            3'b000:  enq_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  enq_data = {{16{ld_half[15]}}, ld_half};
            3'b010:  enq_data = i_ld_data;
            3'b100:  enq_data = {24'h0, ld_byte};
            3'b101:  enq_data = {16'h0, ld_half};
            default: enq_err  = 1'b1;
        endcase
    end
`else
    // Load unit already extended the data; funct3 and offset are not needed here
    logic unused_fmt;
    assign unused_fmt = ^{i_ld_funct3, i_ld_byte_off};
    assign enq_data   = i_ld_data;
    assign enq_err    = 1'b0;
`endif

    // Occupancy and starvation next state
    always_comb begin
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        starve_d = '0;
        stall_d  = 1'b0;
        if (fifo_nonempty && !deq) begin
            // Head is waiting behind the ALU; saturate at the limit.
            starve_d = (starve_q >= STARVE_MAX) ? starve_q : starve_q + STV_W'(1);
            stall_d  = stall_q || (starve_q >= STARVE_MAX);
        end
    end

    // FIFO storage write on enqueue
    always_ff @(posedge i_clk) begin
        if (enq) begin
            q_addr[wr_ptr_q] <= i_ld_rd_addr;
            q_data[wr_ptr_q] <= enq_data;
            q_err[wr_ptr_q]  <= enq_err;
        end
    end

    // FIFO pointers, count and starvation state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    // Registered write port, error pulse and pending flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_addr_q    <= 5'd0;
            rd_data_q    <= 32'h0;
            write_en_q   <= 1'b0;
            ld_err_q     <= 1'b0;
            ld_pending_q <= 1'b0;
        end else begin
            write_en_q <= 1'b0;
            ld_err_q   <= 1'b0;
            if (alu_win) begin
                rd_addr_q  <= i_alu_rd_addr;
                rd_data_q  <= i_alu_rd_data;
                write_en_q <= 1'b1;
            end else if (deq) begin
                // A head for x0 is consumed but never written
                rd_addr_q  <= head_addr;
                rd_data_q  <= head_data;
                write_en_q <= (head_addr != 5'd0);
                ld_err_q   <= head_err;
            end
            // Stays high through the cycle the load sits on the write port
            ld_pending_q <= fifo_nonempty || enq;
        end
    end

    assign o_rd_addr    = rd_addr_q;
    assign o_rd_data    = rd_data_q;
    assign o_write_en   = write_en_q;
    assign o_ld_pending = ld_pending_q;
    assign o_stall_req  = stall_q;
    assign o_ld_err     = ld_err_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed, table-driven bench for wb_stage plus hand-written sequences
// for arbitration, full FIFO, starvation and mid-stream reset.

module tb_wb_stage;

`ifdef WB_LOAD_FMT_EN
    localparam bit FMT = 1'b1;
`else
    localparam bit FMT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd_addr;
    logic [31:0] alu_rd_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd_addr;
    logic [31:0] ld_data;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_byte_off;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        write_en;
    logic        ld_pending;
    logic        stall_req;
    logic        ld_err;

    int n_checks = 0;
    int n_fail   = 0;

    wb_stage #(
        .LD_FIFO_DEPTH(2),
        .STARVE_LIMIT (4)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_alu_valid  (alu_valid),
        .i_alu_rd_addr(alu_rd_addr),
        .i_alu_rd_data(alu_rd_data),
        .i_ld_valid   (ld_valid),
        .o_ld_ready   (ld_ready),
        .i_ld_rd_addr (ld_rd_addr),
        .i_ld_data    (ld_data),
        .i_ld_funct3  (ld_funct3),
        .i_ld_byte_off(ld_byte_off),
        .o_rd_addr    (rd_addr),
        .o_rd_data    (rd_data),
        .o_write_en   (write_en),
        .o_ld_pending (ld_pending),
        .o_stall_req  (stall_req),
        .o_ld_err     (ld_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        alu_v;
        logic [4:0]  alu_rd;
        logic [31:0] alu_d;
        logic        ld_v;
        logic [4:0]  ld_rd;
        logic [31:0] ld_d;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic        exp_we;
        logic [4:0]  exp_rd;
        logic [31:0] exp_d;   // formatted expectation for loads
        logic        exp_err; // formatted expectation for loads
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input string nm, input logic av, input logic [4:0] ard,
                           input logic [31:0] ad, input logic lv, input logic [4:0] lrd,
                           input logic [31:0] ld, input logic [2:0] f3,
                           input logic [1:0] off, input logic we, input logic [4:0] erd,
                           input logic [31:0] ed, input logic eerr);
        vec_t v;
        v.name = nm; v.alu_v = av; v.alu_rd = ard; v.alu_d = ad;
        v.ld_v = lv; v.ld_rd = lrd; v.ld_d = ld; v.f3 = f3; v.off = off;
        v.exp_we = we; v.exp_rd = erd; v.exp_d = ed; v.exp_err = eerr;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid   = 1'b0;
        alu_rd_addr = 5'd0;
        alu_rd_data = 32'h0;
        ld_valid    = 1'b0;
        ld_rd_addr  = 5'd0;
        ld_data     = 32'h0;
        ld_funct3   = 3'b010;
        ld_byte_off = 2'd0;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [31:0] d);
        ld_valid    = 1'b1;
        ld_rd_addr  = rd;
        ld_data     = d;
        ld_funct3   = 3'b010;
        ld_byte_off = 2'd0;
    endtask

    initial begin
        vec_t        v;
        logic [31:0] e_d;
        logic        e_err;

        idle_inputs();
        rst = 1'b1;

        // name, alu_v, alu_rd, alu_d, ld_v, ld_rd, ld_d, f3, off, we, rd, data, err
        add_vec("alu_rd5",  1, 5'd5,  32'h1234_5678, 0, 0, 0, 3'b000, 2'd0,
                1, 5'd5,  32'h1234_5678, 0);
        add_vec("alu_rd0",  1, 5'd0,  32'hAAAA_5555, 0, 0, 0, 3'b000, 2'd0,
                0, 5'd0,  32'h0, 0);
        add_vec("ld_lb3",   0, 0, 0, 1, 5'd7,  32'h80FF_0000, 3'b000, 2'd3,
                1, 5'd7,  32'hFFFF_FF80, 0);
        add_vec("ld_lhu2",  0, 0, 0, 1, 5'd8,  32'h80FF_0000, 3'b101, 2'd2,
                1, 5'd8,  32'h0000_80FF, 0);
        add_vec("ld_lw",    0, 0, 0, 1, 5'd9,  32'h80FF_0000, 3'b010, 2'd0,
                1, 5'd9,  32'h80FF_0000, 0);
        add_vec("ld_bad3",  0, 0, 0, 1, 5'd10, 32'h80FF_0000, 3'b011, 2'd0,
                1, 5'd10, 32'h0, 1);
        add_vec("ld_lbu1",  0, 0, 0, 1, 5'd11, 32'h1234_A5C3, 3'b100, 2'd1,
                1, 5'd11, 32'h0000_00A5, 0);
        add_vec("ld_lh1",   0, 0, 0, 1, 5'd12, 32'h1234_A5C3, 3'b001, 2'd1,
                1, 5'd12, 32'hFFFF_A5C3, 0);
        add_vec("ld_lb0",   0, 0, 0, 1, 5'd13, 32'h1234_A5C3, 3'b000, 2'd0,
                1, 5'd13, 32'hFFFF_FFC3, 0);
        add_vec("ld_bad7",  0, 0, 0, 1, 5'd14, 32'h0000_0001, 3'b111, 2'd0,
                1, 5'd14, 32'h0, 1);
        add_vec("ld_x0",    0, 0, 0, 1, 5'd0,  32'h5555_5555, 3'b010, 2'd0,
                0, 5'd0,  32'h0, 0);
        add_vec("alu_rd31", 1, 5'd31, 32'hDEAD_BEEF, 0, 0, 0, 3'b000, 2'd0,
                1, 5'd31, 32'hDEAD_BEEF, 0);

        // Reset state
        tick();
        check("rst_ready", 32'(ld_ready), 32'd0);
        tick();
        check("rst_we", 32'(write_en), 32'd0);
        check("rst_rd", 32'(rd_addr), 32'd0);
        check("rst_data", rd_data, 32'd0);
        check("rst_pending", 32'(ld_pending), 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_err", 32'(ld_err), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(ld_ready), 32'd1);
        check("post_rst_we", 32'(write_en), 32'd0);

        // Table-driven single transactions
        for (int i = 0; i < vq.size(); i++) begin
            v           = vq[i];
            alu_valid   = v.alu_v;
            alu_rd_addr = v.alu_rd;
            alu_rd_data = v.alu_d;
            ld_valid    = v.ld_v;
            ld_rd_addr  = v.ld_rd;
            ld_data     = v.ld_d;
            ld_funct3   = v.f3;
            ld_byte_off = v.off;
            tick();
            idle_inputs();
            if (v.ld_v) tick();
            e_d   = (v.ld_v && !FMT) ? v.ld_d : v.exp_d;
            e_err = (v.ld_v && !FMT) ? 1'b0 : v.exp_err;
            check({v.name, "_we"}, 32'(write_en), 32'(v.exp_we));
            if (v.exp_we) begin
                check({v.name, "_rd"}, 32'(rd_addr), 32'(v.exp_rd));
                check({v.name, "_data"}, rd_data, e_d);
            end
            check({v.name, "_err"}, 32'(ld_err), 32'(e_err));
            tick();
            check({v.name, "_err_pulse"}, 32'(ld_err), 32'd0);
        end

        // Arbitration: load offered in cycle 0, ALU valid in cycles 1-2
        drive_load(5'd20, 32'hCAFE_0001);
        tick();                                   // cycle 1
        idle_inputs();
        check("arb_c1_pending", 32'(ld_pending), 32'd1);
        check("arb_c1_we", 32'(write_en), 32'd0);
        alu_valid = 1'b1; alu_rd_addr = 5'd3; alu_rd_data = 32'h0000_0A0A;
        tick();                                   // cycle 2
        check("arb_c2_we", 32'(write_en), 32'd1);
        check("arb_c2_rd", 32'(rd_addr), 32'd3);
        check("arb_c2_pending", 32'(ld_pending), 32'd1);
        alu_rd_addr = 5'd4; alu_rd_data = 32'h0000_0B0B;
        tick();                                   // cycle 3
        check("arb_c3_rd", 32'(rd_addr), 32'd4);
        check("arb_c3_data", rd_data, 32'h0000_0B0B);
        check("arb_c3_pending", 32'(ld_pending), 32'd1);
        idle_inputs();
        tick();                                   // cycle 4
        check("arb_c4_we", 32'(write_en), 32'd1);
        check("arb_c4_rd", 32'(rd_addr), 32'd20);
        check("arb_c4_data", rd_data, 32'hCAFE_0001);
        check("arb_c4_pending", 32'(ld_pending), 32'd1);
        tick();                                   // cycle 5
        check("arb_c5_we", 32'(write_en), 32'd0);
        check("arb_c5_pending", 32'(ld_pending), 32'd0);

        // Full FIFO: third load must not be accepted, even in the dequeue cycle
        alu_valid = 1'b1; alu_rd_addr = 5'd1; alu_rd_data = 32'h1;
        drive_load(5'd21, 32'h0000_D001);
        tick();
        drive_load(5'd22, 32'h0000_D002);
        tick();
        check("full_ready_a", 32'(ld_ready), 32'd0);
        drive_load(5'd23, 32'h0000_D003);
        tick();
        check("full_ready_b", 32'(ld_ready), 32'd0);
        alu_valid = 1'b0;                         // head dequeues at the next edge
        tick();
        ld_valid = 1'b0;
        check("full_deq1_rd", 32'(rd_addr), 32'd21);
        check("full_deq1_data", rd_data, 32'h0000_D001);
        check("full_ready_after", 32'(ld_ready), 32'd1);
        tick();
        check("full_deq2_we", 32'(write_en), 32'd1);
        check("full_deq2_rd", 32'(rd_addr), 32'd22);
        tick();
        check("full_no_third", 32'(write_en), 32'd0);
        check("full_pending", 32'(ld_pending), 32'd0);
        idle_inputs();
        tick();

        // Starvation: one queued load, ALU held valid
        alu_valid = 1'b1; alu_rd_addr = 5'd2; alu_rd_data = 32'h2;
        drive_load(5'd16, 32'h0000_00AA);
        tick();
        ld_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("starve_c%0d_stall", k), 32'(stall_req), 32'd0);
            tick();
        end
        check("starve_stall_up", 32'(stall_req), 32'd1);
        alu_valid = 1'b0;
        tick();
        check("starve_ld_we", 32'(write_en), 32'd1);
        check("starve_ld_rd", 32'(rd_addr), 32'd16);
        check("starve_ld_data", rd_data, 32'h0000_00AA);
        check("starve_stall_down", 32'(stall_req), 32'd0);
        idle_inputs();
        tick();

        // Reset mid-stream with two queued loads
        alu_valid = 1'b1; alu_rd_addr = 5'd6; alu_rd_data = 32'h6;
        drive_load(5'd17, 32'h0000_E001);
        tick();
        drive_load(5'd18, 32'h0000_E002);
        tick();
        ld_valid = 1'b0;
        alu_rd_addr = 5'd25; alu_rd_data = 32'h0000_0025;
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(ld_ready), 32'd0);
        tick();
        check("mid_rst_we", 32'(write_en), 32'd0);
        check("mid_rst_rd", 32'(rd_addr), 32'd0);
        check("mid_rst_data", rd_data, 32'd0);
        check("mid_rst_pending", 32'(ld_pending), 32'd0);
        check("mid_rst_stall", 32'(stall_req), 32'd0);
        check("mid_rst_err", 32'(ld_err), 32'd0);
        rst = 1'b0;
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("post_mid_we%0d", k), 32'(write_en), 32'd0);
            check($sformatf("post_mid_ready%0d", k), 32'(ld_ready), 32'd1);
            check($sformatf("post_mid_pending%0d", k), 32'(ld_pending), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
